// File: rtl/usb_line_state_detector.sv
// usb_line_state_detector: classifies the sampled USB line as valid EOP, malformed EOP, bus reset or SE1 error
// Optional feature macro: USB_LINE_ERR_COUNT_EN (adds err_clr input and 8-bit err_count output)
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   d_plus_sync, d_minus_sync  synchronised line inputs
//   shift_enable               bit-sample strobe; the line is sampled only when high
//   eop, eop_err, se1_err      one-cycle pulses following the sample that caused them
//   bus_reset                  level, high while SE0 has been held for RESET_BITS samples or more
//   line_state                 last sampled {D+, D-}
//   err_clr, err_count         error counter clear / saturating error count (optional)
module usb_line_state_detector #(
    parameter int SE0_MIN_BITS = 2,
    parameter int SE0_MAX_BITS = 3,
    parameter int RESET_BITS   = 30
) (
    input  logic       clk,
    input  logic       n_rst,
`ifdef USB_LINE_ERR_COUNT_EN
    input  logic       err_clr,
    output logic [7:0] err_count,
`endif
    input  logic       d_plus_sync,
    input  logic       d_minus_sync,
    input  logic       shift_enable,
    output logic       eop,
    output logic       eop_err,
    output logic       bus_reset,
    output logic       se1_err,
    output logic [1:0] line_state
);
    localparam int CNT_W = $clog2(RESET_BITS + 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(SE0_MIN_BITS);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(SE0_MAX_BITS);
    localparam logic [CNT_W-1:0] RST_C = CNT_W'(RESET_BITS);

    typedef enum logic [1:0] {IDLE, SE0_RUN, BUS_RST} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] se0_cnt_q;
    logic [1:0]       line_state_q;
    logic             eop_q, eop_err_q, bus_reset_q, se1_err_q;
    logic [1:0]       line;
    logic             is_se0, is_se1, is_j, good_eop;

    assign line     = {d_plus_sync, d_minus_sync};
    assign is_se0   = line == 2'b00;
    assign is_se1   = line == 2'b11;
    assign is_j     = line == 2'b10;
    // se0_cnt_q still holds the run length before this terminating sample
    assign good_eop = is_j && se0_cnt_q >= MIN_C && se0_cnt_q <= MAX_C;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            se0_cnt_q    <= '0;
            line_state_q <= 2'b10;
            eop_q        <= 1'b0;
            eop_err_q    <= 1'b0;
            bus_reset_q  <= 1'b0;
            se1_err_q    <= 1'b0;
        end else begin
            eop_q     <= 1'b0;
            eop_err_q <= 1'b0;
            se1_err_q <= 1'b0;
            if (shift_enable) begin
                line_state_q <= line;
                se1_err_q    <= is_se1;
                se0_cnt_q    <= !is_se0 ? '0 : se0_cnt_q == RST_C ? RST_C : se0_cnt_q + ONE;
                case (state_q)
                    IDLE: if (is_se0) state_q <= SE0_RUN;
                    SE0_RUN: begin
                        if (is_se0) begin
                            if (se0_cnt_q + ONE == RST_C) begin
                                state_q     <= BUS_RST;
                                bus_reset_q <= 1'b1;
                            end
                        end else begin
                            eop_q     <= good_eop;
                            eop_err_q <= !good_eop;
                            state_q   <= IDLE;
                        end
                    end
                    BUS_RST: begin
                        if (!is_se0) begin
                            bus_reset_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign eop        = eop_q;
    assign eop_err    = eop_err_q;
    assign bus_reset  = bus_reset_q;
    assign se1_err    = se1_err_q;
    assign line_state = line_state_q;

`ifdef USB_LINE_ERR_COUNT_EN
    logic [7:0] err_count_q;

    // counts cycles with an error pulse visible on the outputs; clear has priority
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) err_count_q <= '0;
        else err_count_q <= err_clr ? 8'd0
                          : ((eop_err_q || se1_err_q) && err_count_q != 8'hFF) ? err_count_q + 8'd1
                          : err_count_q;
    end

    assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_usb_line_state_detector.sv
// tb_usb_line_state_detector: drives a default and a narrow-parameter detector with shared stimulus against a run-length model
module tb_usb_line_state_detector;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       dp = 1'b1, dm = 1'b0, se_i = 1'b0, clr_i = 1'b0;
    logic [1:0] eop_w, err_w, br_w, se1_w;
    logic [1:0] ls_w [2];
    logic [7:0] ec_w [2];

    int vectors = 0;
    int miscompares = 0;

    int minb [2] = '{2, 1};
    int maxb [2] = '{3, 1};
    int rb   [2] = '{30, 5};
    int run  [2];
    int e_cnt [2];
    logic e_eop [2];
    logic e_err [2];
    logic e_br  [2];
    logic [1:0] e_ls;
    logic e_se1;

    always #5 clk = ~clk;

    usb_line_state_detector u0 (
        .clk(clk), .n_rst(n_rst),
`ifdef USB_LINE_ERR_COUNT_EN
        .err_clr(clr_i), .err_count(ec_w[0]),
`endif
        .d_plus_sync(dp), .d_minus_sync(dm), .shift_enable(se_i),
        .eop(eop_w[0]), .eop_err(err_w[0]), .bus_reset(br_w[0]), .se1_err(se1_w[0]), .line_state(ls_w[0])
    );

    usb_line_state_detector #(.SE0_MIN_BITS(1), .SE0_MAX_BITS(1), .RESET_BITS(5)) u1 (
        .clk(clk), .n_rst(n_rst),
`ifdef USB_LINE_ERR_COUNT_EN
        .err_clr(clr_i), .err_count(ec_w[1]),
`endif
        .d_plus_sync(dp), .d_minus_sync(dm), .shift_enable(se_i),
        .eop(eop_w[1]), .eop_err(err_w[1]), .bus_reset(br_w[1]), .se1_err(se1_w[1]), .line_state(ls_w[1])
    );

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[u%0d] observed=%0h expected=%0h at %0t", tag, i, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk("eop", i, 32'(eop_w[i]), 32'(e_eop[i]));
            chk("eop_err", i, 32'(err_w[i]), 32'(e_err[i]));
            chk("bus_reset", i, 32'(br_w[i]), 32'(e_br[i]));
            chk("se1_err", i, 32'(se1_w[i]), 32'(e_se1));
            chk("line_state", i, 32'(ls_w[i]), 32'(e_ls));
`ifdef USB_LINE_ERR_COUNT_EN
            chk("err_count", i, 32'(ec_w[i]), 32'(e_cnt[i]));
`endif
        end
    endtask

    // One clock: apply inputs, predict the post-edge outputs, then check them
    task automatic cyc(input logic [1:0] ls, input logic se, input logic clr);
        logic ok;
        {dp, dm} = ls;
        se_i  = se;
        clr_i = clr;
        for (int i = 0; i < 2; i++) begin
            if (clr) e_cnt[i] = 0;
            else if ((e_err[i] || e_se1) && e_cnt[i] < 255) e_cnt[i] = e_cnt[i] + 1;
            e_eop[i] = 1'b0;
            e_err[i] = 1'b0;
        end
        e_se1 = se && ls == 2'b11;
        if (se) begin
            e_ls = ls;
            for (int i = 0; i < 2; i++) begin
                if (ls == 2'b00) begin
                    run[i]++;
                    e_br[i] = run[i] >= rb[i];
                end else begin
                    if (run[i] > 0 && run[i] < rb[i]) begin
                        ok = ls == 2'b10 && run[i] >= minb[i] && run[i] <= maxb[i];
                        e_eop[i] = ok;
                        e_err[i] = !ok;
                    end
                    run[i]  = 0;
                    e_br[i] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic samp(input logic [1:0] ls, input int n);
        for (int k = 0; k < n; k++) begin
            cyc(ls, 1'b1, 1'b0);
            repeat (7) cyc(ls, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        se_i  = 1'b0;
        clr_i = 1'b0;
        e_ls  = 2'b10;
        e_se1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            run[i]   = 0;
            e_cnt[i] = 0;
            e_eop[i] = 1'b0;
            e_err[i] = 1'b0;
            e_br[i]  = 1'b0;
        end
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        n_rst = 1'b1;
    endtask

    initial begin
        logic [1:0] rl;
        int r;
        @(posedge clk);
        #1;
        do_reset();
        // valid two-bit EOP
        samp(2'b10, 1); samp(2'b00, 2); samp(2'b10, 1);
        // too short, too long, longest legal
        samp(2'b00, 1); samp(2'b10, 1);
        samp(2'b00, 4); samp(2'b10, 1);
        samp(2'b00, 3); samp(2'b10, 1);
        // bus reset entry, hold and exit
        samp(2'b00, 30); samp(2'b00, 10); samp(2'b10, 1);
        // SE1 ending a run, then J
        samp(2'b00, 2); samp(2'b11, 1); samp(2'b10, 1);
        // reset discards a run in progress
        samp(2'b00, 2);
        do_reset();
        samp(2'b10, 1);
        // back-to-back runs and K-terminated runs for the error counter
        do_reset();
        samp(2'b00, 1); samp(2'b10, 1); samp(2'b00, 2); samp(2'b10, 1);
        for (int k = 0; k < 3; k++) begin
            samp(2'b00, 1); samp(2'b01, 1);
        end
        cyc(2'b10, 1'b0, 1'b1);
        cyc(2'b10, 1'b0, 1'b0);
        // randomized line activity with irregular strobes and occasional clears
        for (int k = 0; k < 400; k++) begin
            r  = int'($urandom_range(0, 9));
            rl = r < 6 ? 2'b00 : r < 8 ? 2'b10 : r == 8 ? 2'b01 : 2'b11;
            cyc(rl, 1'b1, $urandom_range(0, 15) == 0);
            repeat ($urandom_range(0, 2)) cyc(rl, 1'b0, $urandom_range(0, 15) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
